// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one fixed-latency CORDIC pipeline between two
// requesters; results return through tagged per-requester FWFT FIFOs.
module cordic_scheduler #(
  parameter int DATA_WIDTH   = 22,
  parameter int PIPE_LATENCY = 17,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_target,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_target,
  output logic                  req1_ready,
  output logic                  res0_valid,
  output logic [DATA_WIDTH-1:0] res0_data,
  input  logic                  res0_ready,
  output logic                  res1_valid,
  output logic [DATA_WIDTH-1:0] res1_data,
  input  logic                  res1_ready,
  output logic                  cordic_clk_en,
  output logic [DATA_WIDTH-1:0] cordic_target,
  input  logic [DATA_WIDTH-1:0] cordic_result,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  logic [1:0]            req_valid;
  logic [DATA_WIDTH-1:0] req_target [2];
  logic [1:0]            res_ready;
  logic [1:0]            res_valid;
  logic [DATA_WIDTH-1:0] res_data [2];
  logic [1:0]            credit_ok;
  logic [1:0]            busy_vec;
  logic [1:0]            cand;
  logic [1:0]            grant;
  logic                  accept;
  logic                  accept_id;
  logic                  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [PIPE_LATENCY-1:0] tag_v_q, tag_id_q;
  logic                  retire;
  logic                  retire_id;

  assign req_valid     = {req1_valid, req0_valid};
  assign req_target[0] = req0_target;
  assign req_target[1] = req1_target;
  assign res_ready     = {res1_ready, res0_ready};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Candidates are gated by rst so ready stays low while reset is held.
  always_comb begin
    cand  = req_valid & credit_ok & {2{~rst}};
    grant = cand;
    if (cand == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    accept    = |grant;
    accept_id = grant[1];
    ptr_d     = accept ? ~accept_id : ptr_q;
    target_d  = accept ? req_target[accept_id] : '0;
  end

  assign retire    = tag_v_q[PIPE_LATENCY-1];
  assign retire_id = tag_id_q[PIPE_LATENCY-1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= 1'b0;
      target_q <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      target_q <= target_d;
      tag_v_q  <= {tag_v_q[PIPE_LATENCY-2:0], accept};
      tag_id_q <= {tag_id_q[PIPE_LATENCY-2:0], accept_id};
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic                  push, pop, acc;
    logic [CNT_W-1:0]      cnt_q, cnt_d, infl_q, infl_d;
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    assign acc  = grant[g];
    assign push = retire & (retire_id == 1'(g));
    assign pop  = res_valid[g] & res_ready[g];

    assign res_valid[g] = (cnt_q != '0);
    assign res_data[g]  = res_valid[g] ? mem_q[rd_q] : '0;
    assign credit_ok[g] = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_LIM;
    assign busy_vec[g]  = (cnt_q != '0) | (infl_q != '0);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      cnt_d  = cnt_q;
      infl_d = infl_q;
      wr_d   = push ? ptr_inc(wr_q) : wr_q;
      rd_d   = pop ? ptr_inc(rd_q) : rd_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
      case ({acc, push})
        2'b10:   infl_d = infl_q + 1'b1;
        2'b01:   infl_d = infl_q - 1'b1;
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        infl_q <= '0;
        wr_q   <= '0;
        rd_q   <= '0;
      end else begin
        cnt_q  <= cnt_d;
        infl_q <= infl_d;
        wr_q   <= wr_d;
        rd_q   <= rd_d;
      end
    end

    // NOTE: storage is not reset; the zeroed count/pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= cordic_result;
    end
  end

  assign req0_ready    = grant[0];
  assign req1_ready    = grant[1];
  assign res0_valid    = res_valid[0];
  assign res1_valid    = res_valid[1];
  assign res0_data     = res_data[0];
  assign res1_data     = res_data[1];
  assign cordic_clk_en = ~rst;
  assign cordic_target = target_q;
  assign busy          = |busy_vec;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench: XOR stub pipeline plus per-requester scoreboard queues.
module tb_cordic_scheduler;

  localparam int W = 22;
  localparam int P = 17;
  localparam int D = 4;
  localparam logic [W-1:0] MASK = 22'h3FFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_target, req1_target;
  logic         res0_valid, res1_valid, res0_ready, res1_ready;
  logic [W-1:0] res0_data, res1_data;
  logic         cordic_clk_en, busy;
  logic [W-1:0] cordic_target, cordic_result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q0[$], exp_q1[$];
  int           grant_log[$];
  int           acc0 = 0, acc1 = 0, pop0 = 0, pop1 = 0, vcnt = 0;
  int           seen0 = 0, seen1 = 0;

  cordic_scheduler #(.DATA_WIDTH(W), .PIPE_LATENCY(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_target(req0_target), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_target(req1_target), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_data(res0_data), .res0_ready(res0_ready),
    .res1_valid(res1_valid), .res1_data(res1_data), .res1_ready(res1_ready),
    .cordic_clk_en(cordic_clk_en), .cordic_target(cordic_target),
    .cordic_result(cordic_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub pipeline: a target presented after edge E is sampled as a result at edge E+P.
  logic [W-1:0] stub_q [P-1];
  always @(posedge clk) begin
    if (cordic_clk_en) begin
      stub_q[0] <= cordic_target;
      for (int i = 1; i < P - 1; i++) stub_q[i] <= stub_q[i-1];
    end
  end
  assign cordic_result = stub_q[P-2] ^ MASK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(req0_target ^ MASK);
        grant_log.push_back(0);
        acc0 <= acc0 + 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(req1_target ^ MASK);
        grant_log.push_back(1);
        acc1 <= acc1 + 1;
      end
      if (res0_valid || res1_valid) vcnt <= vcnt + 1;
      if (res0_valid && res0_ready) begin
        check("res0_expected", {31'd0, exp_q0.size() != 0}, 32'd1);
        if (exp_q0.size() != 0) check("res0_data", res0_data, exp_q0.pop_front());
        pop0 <= pop0 + 1;
      end
      if (res1_valid && res1_ready) begin
        check("res1_expected", {31'd0, exp_q1.size() != 0}, 32'd1);
        if (exp_q1.size() != 0) check("res1_data", res1_data, exp_q1.pop_front());
        pop1 <= pop1 + 1;
      end
    end
  end

  // One cycle of stimulus; a fresh random target follows each accepted one.
  task automatic step();
    @(posedge clk); #1;
    if (acc0 != seen0) begin seen0 = acc0; req0_target = W'($urandom); end
    if (acc1 != seen1) begin seen1 = acc1; req1_target = W'($urandom); end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, n < 300}, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n, a0, a1, p0, p1, vc, t;
    bit got;

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_target = 22'h012345; req1_target = 22'h054321;
    res0_ready = 1'b1; res1_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_res_valid0", {30'd0, res1_valid, res0_valid}, 32'd0);
    check("rst_res0_data", res0_data, 32'd0);
    check("rst_res1_data", res1_data, 32'd0);
    check("rst_cordic_target", cordic_target, 32'd0);
    check("rst_clk_en", {31'd0, cordic_clk_en}, 32'd0);
    check("rst_busy0", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("clk_en_after_rst", {31'd0, cordic_clk_en}, 32'd1);

    // Single request and latency.
    @(posedge clk); #1;
    req0_target = 22'h000100;
    req0_valid  = 1'b1;
    @(negedge clk);
    check("single_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    p0 = pop0;
    n = 0; got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) check("target_reg", cordic_target, 32'h000100);
      if (n == 2) check("target_idle", cordic_target, 32'd0);
      if (res0_valid) begin
        got = 1'b1;
        check("single_data", res0_data, 32'h3FFEFF);
      end
    end
    check("single_latency", n, P + 1);
    repeat (10) @(posedge clk);
    #1;
    check("single_once", pop0 - p0, 1);

    // Contention from reset.
    pulse_rst();
    grant_log.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (40) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("contention_idle");
    check("grant_count", {31'd0, grant_log.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("grant_%0d", i), grant_log[i], i % 2);

    // Backpressure on requester 1.
    pulse_rst();
    res1_ready = 1'b0;
    a0 = acc0; a1 = acc1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (60) step();
    check("bp_req1_accepts", acc1 - a1, D);
    check("bp_req0_progress", {31'd0, (acc0 - a0) >= 8}, 32'd1);
    check("bp_res1_valid", {31'd0, res1_valid}, 32'd1);
    check("bp_busy", {31'd0, busy}, 32'd1);

    // Drain a single entry.
    a1 = acc1; p1 = pop1;
    res1_ready = 1'b1;
    step();
    res1_ready = 1'b0;
    repeat (40) step();
    check("drain_req1_accepts", acc1 - a1, 1);
    check("drain_pops", pop1 - p1, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    res1_ready = 1'b1;
    wait_idle("drain_idle");

    // Mid-flight reset.
    t = acc0 + acc1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while ((acc0 + acc1) - t < 5 && n < 20) begin
      step();
      n++;
    end
    check("mf_inflight", (acc0 + acc1) - t, 5);
    pulse_rst();
    vc = vcnt;
    repeat (30) step();
    check("mf_no_result", vcnt - vc, 0);
    check("mf_busy", {31'd0, busy}, 32'd0);
    p1 = pop1; a1 = acc1;
    req1_target = 22'h2ABCDE;
    req1_valid  = 1'b1;
    n = 0;
    while (acc1 == a1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    req1_valid = 1'b0;
    check("mf_accept", acc1 - a1, 1);
    wait_idle("mf_idle");
    check("mf_result", pop1 - p1, 1);

    check("sb0_empty", exp_q0.size(), 0);
    check("sb1_empty", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
